bp_io_cmd_arbiter: RTL and testbench
====================================

BP_IO_CMD_ARBITER -- requirements
Module: bp_io_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_ch_p, default 2, giving the number of IO command sources (legal range 2..8).
REQ-002 SHALL have parameter msg_width_p, default 128, giving the packed BedRock IO message width in bits.
REQ-003 SHALL have parameter els_p, default 8, giving the order-FIFO depth, which is the maximum number of commands in flight (power of 2, legal range 2..64).
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock; all state is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit: synchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port ch_cmd_i, input, num_ch_p x msg_width_p: per-channel command.
REQ-007 SHALL have ports ch_cmd_v_i (input) and ch_cmd_yumi_o (output), each num_ch_p bits: per-channel valid, and per-channel consume.
REQ-008 SHALL have port ch_en_i, input, num_ch_p bits: per-channel enable; a disabled channel is never granted.
REQ-009 SHALL have ports cmd_o (output, msg_width_p), cmd_v_o (output, 1) and cmd_ready_and_i (input, 1): the merged downstream command.
REQ-010 SHALL have ports resp_i (input, msg_width_p), resp_v_i (input, 1) and resp_yumi_o (output, 1): the downstream response.
REQ-011 SHALL have ports ch_resp_o (output, msg_width_p, shared), ch_resp_v_o (output, num_ch_p) and ch_resp_ready_and_i (input, num_ch_p): the per-channel response.
REQ-012 SHALL have port inflight_o, output, log2(els_p)+1 bits: the current count of commands in flight.
REQ-013 SHALL have port orphan_o, output, 1 bit: sticky flag, set by a response arriving with nothing in flight.

Function
REQ-014 SHALL form the eligible set as ch_cmd_v_i & ch_en_i, and SHALL treat it as empty whenever the order FIFO is full.
REQ-015 SHALL grant one eligible channel per cycle, round-robin, starting the search at the priority pointer and wrapping from num_ch_p-1 to 0.
REQ-016 SHALL drive cmd_v_o combinationally as "eligible set non-empty", and SHALL drive cmd_o as ch_cmd_i of the granted channel (zero-cycle latency).
REQ-017 SHALL keep the grant unchanged while cmd_v_o=1 and cmd_ready_and_i=0, as long as that channel stays valid and enabled; it SHALL NOT re-arbitrate in this case.
REQ-018 SHALL assert ch_cmd_yumi_o[g] only when cmd_v_o=1, cmd_ready_and_i=1 and g is the granted channel; all other bits SHALL be 0.
REQ-019 SHALL, on each command handshake, push g into the order FIFO and set the priority pointer to (g+1) mod num_ch_p; otherwise the pointer SHALL hold.
REQ-020 SHALL deliver responses in command order; the FIFO head h selects the destination channel.
REQ-021 SHALL drive ch_resp_o = resp_i, and SHALL drive ch_resp_v_o[h] = resp_v_i & FIFO non-empty, with all other bits 0.
REQ-022 SHALL drive resp_yumi_o = resp_v_i & FIFO non-empty & ch_resp_ready_and_i[h], and SHALL pop the FIFO on resp_yumi_o.
REQ-023 SHALL never set resp_yumi_o when the FIFO is empty; a resp_v_i in that state SHALL set orphan_o, and orphan_o SHALL stay set until reset.
REQ-024 SHALL update inflight_o as +1 on a push and -1 on a pop; a simultaneous push and pop SHALL leave it unchanged.
REQ-025 SHALL allow a push and a pop in the same cycle when the FIFO is neither full nor empty, and SHALL allow a pop-only when it is full; a push when full is impossible per REQ-014.
REQ-026 SHALL, when ch_en_i of the granted channel deasserts mid-stall, re-arbitrate in the same cycle; commands already in flight to that channel SHALL still have their responses routed to it.

Reset
REQ-027 SHALL, during reset, empty the FIFO, set the priority pointer to 0, and clear inflight_o and orphan_o.
REQ-028 SHALL hold cmd_v_o, ch_cmd_yumi_o, resp_yumi_o and ch_resp_v_o at 0 during reset, regardless of inputs.
REQ-029 SHALL, on reset asserted mid-operation, discard all in-flight records; responses arriving afterwards SHALL be treated as orphans.

Structure
REQ-030 SHALL instantiate one sub-module, bsg_fifo_1r1w_small, for the order FIFO (width log2(num_ch_p), depth els_p).
REQ-031 SHALL keep the grant-id width helper and the BedRock IO message typedefs in bp_me_pkg; no local typedefs.
REQ-032 SHALL use round-robin logic local to the block; no multi-cycle paths and no additional clocks.

Verification
REQ-033 SHALL cover: channels 0 and 1 both valid continuously, ready=1 -> grants alternate 0,1,0,1, and after 4 responses inflight_o returns to 0.
REQ-034 SHALL cover: els_p=8 with responses withheld -> exactly 8 yumis, then cmd_v_o=0 and inflight_o=8; one response -> one further grant in the next cycle.
REQ-035 SHALL cover: cmd_ready_and_i=0 for 5 cycles with channel 1 granted and channel 0 asserting -> cmd_o is stable on channel 1 for all 5 cycles.
REQ-036 SHALL cover: commands issued in order ch2, ch0, ch2 (num_ch_p=4) -> responses appear on ch_resp_v_o bits 2, 0, 2 in that order; with ch_resp_ready_and_i[0]=0, resp_yumi_o holds 0.
REQ-037 SHALL cover: resp_v_i=1 at inflight_o=0 -> resp_yumi_o=0 and orphan_o=1 next cycle, cleared only by reset_i=0.
REQ-038 SHALL cover: reset_i=0 asserted with 3 commands in flight -> outputs at 0 and inflight_o=0 one cycle later; after release, grants resume starting at channel 0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - BedRock IO message types and grant-id width helpers
package bp_me_pkg;

   localparam int bp_io_msg_width_gp = 128;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  size;
      logic [3:0]  msg_type;
      logic [51:0] addr;
   } bp_io_msg_s;

   typedef enum logic [0:0] {
      arb_idle_s = 1'b0,
      arb_hold_s = 1'b1
   } arb_state_e;

   function automatic int gnt_id_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int count_width(input int els);
      return $clog2(els) + 1;
   endfunction

endpackage

// File: rtl/bp_io_cmd_arbiter_if.sv
// rtl/bp_io_cmd_arbiter_if.sv - channel command/response bundle for the IO command arbiter
interface bp_io_cmd_arbiter_if #(
   parameter int num_ch_p    = 2,
   parameter int msg_width_p = 128,
   parameter int els_p       = 8
);
   import bp_me_pkg::*;

   logic [num_ch_p-1:0][msg_width_p-1:0] ch_cmd_i;
   logic [num_ch_p-1:0]                  ch_cmd_v_i;
   logic [num_ch_p-1:0]                  ch_cmd_yumi_o;
   logic [num_ch_p-1:0]                  ch_en_i;
   logic [msg_width_p-1:0]               cmd_o;
   logic                                 cmd_v_o;
   logic                                 cmd_ready_and_i;
   logic [msg_width_p-1:0]               resp_i;
   logic                                 resp_v_i;
   logic                                 resp_yumi_o;
   logic [msg_width_p-1:0]               ch_resp_o;
   logic [num_ch_p-1:0]                  ch_resp_v_o;
   logic [num_ch_p-1:0]                  ch_resp_ready_and_i;
   logic [count_width(els_p)-1:0]        inflight_o;
   logic                                 orphan_o;

   modport slave (
      input  ch_cmd_i, ch_cmd_v_i, ch_en_i, cmd_ready_and_i, resp_i, resp_v_i, ch_resp_ready_and_i,
      output ch_cmd_yumi_o, cmd_o, cmd_v_o, resp_yumi_o, ch_resp_o, ch_resp_v_o, inflight_o, orphan_o
   );

   modport master (
      output ch_cmd_i, ch_cmd_v_i, ch_en_i, cmd_ready_and_i, resp_i, resp_v_i, ch_resp_ready_and_i,
      input  ch_cmd_yumi_o, cmd_o, cmd_v_o, resp_yumi_o, ch_resp_o, ch_resp_v_o, inflight_o, orphan_o
   );

endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small one-read one-write FIFO with occupancy count
module bsg_fifo_1r1w_small
   import bp_me_pkg::*;
#(
   parameter int width_p = 1,
   parameter int els_p   = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          v_i,
   input  logic [width_p-1:0]            data_i,
   output logic                          ready_o,
   output logic                          v_o,
   output logic [width_p-1:0]            data_o,
   input  logic                          yumi_i,
   output logic [count_width(els_p)-1:0] count_o
);
   localparam int ptr_width_lp   = $clog2(els_p);
   localparam int count_width_lp = count_width(els_p);

   logic [width_p-1:0]        mem_r [els_p];
   logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
   logic [count_width_lp-1:0] count_r;
   logic                      enq, deq;

   assign ready_o = (count_r != count_width_lp'(els_p));
   assign v_o     = (count_r != '0);
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign data_o  = mem_r[rptr_r];
   assign count_o = count_r;

   // pointers wrap on their own because the depth is a power of two
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq) wptr_r <= wptr_r + 1'b1;
         if (deq) rptr_r <= rptr_r + 1'b1;
         if (enq && !deq)      count_r <= count_r + 1'b1;
         else if (deq && !enq) count_r <= count_r - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// rtl/bp_io_cmd_arbiter.sv - round-robin IO command merge with in-order response return
module bp_io_cmd_arbiter
   import bp_me_pkg::*;
#(
   parameter int num_ch_p    = 2,
   parameter int msg_width_p = 128,
   parameter int els_p       = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   bp_io_cmd_arbiter_if.slave bus
);
   localparam int id_width_lp    = gnt_id_width(num_ch_p);
   localparam int count_width_lp = count_width(els_p);

   arb_state_e                state_r, state_n;
   logic [id_width_lp-1:0]    ptr_r, ptr_n, hold_id_r, hold_id_n;
   logic [id_width_lp-1:0]    rr_id, gnt_id, head_id;
   logic [num_ch_p-1:0]       eligible, elig_rot;
   logic [2*num_ch_p-1:0]     elig_dbl;
   logic                      cmd_v, push, pop, resp_live;
   logic                      fifo_ready, fifo_v, orphan_r;
   logic [count_width_lp-1:0] fifo_count;

   // reset and a full order FIFO both empty the eligible set, silencing every command-side output
   assign eligible = bus.ch_cmd_v_i & bus.ch_en_i & {num_ch_p{fifo_ready & reset_i}};
   assign elig_dbl = {eligible, eligible} >> ptr_r;
   assign elig_rot = elig_dbl[num_ch_p-1:0];
   assign cmd_v    = |eligible;
   assign push     = cmd_v & bus.cmd_ready_and_i;

   always_comb begin
      rr_id = ptr_r;
      for (int k = num_ch_p - 1; k >= 0; k--) begin
         if (elig_rot[k]) rr_id = id_width_lp'((int'(ptr_r) + k) % num_ch_p);
      end
   end

   // a stalled grant sticks only while its channel remains eligible
   assign gnt_id = (state_r == arb_hold_s && eligible[hold_id_r]) ? hold_id_r : rr_id;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_r   <= arb_idle_s;
         ptr_r     <= '0;
         hold_id_r <= '0;
      end else begin
         state_r   <= state_n;
         ptr_r     <= ptr_n;
         hold_id_r <= hold_id_n;
      end
   end

   always_comb begin
      state_n   = arb_idle_s;
      hold_id_n = hold_id_r;
      ptr_n     = ptr_r;
      if (cmd_v && !bus.cmd_ready_and_i) begin
         state_n   = arb_hold_s;
         hold_id_n = gnt_id;
      end
      if (push) ptr_n = (gnt_id == id_width_lp'(num_ch_p - 1)) ? '0 : gnt_id + 1'b1;
   end

   always_comb begin
      bus.cmd_v_o       = cmd_v;
      bus.cmd_o         = bus.ch_cmd_i[gnt_id];
      bus.ch_cmd_yumi_o = '0;
      if (push) bus.ch_cmd_yumi_o[gnt_id] = 1'b1;
   end

   bsg_fifo_1r1w_small #(
      .width_p (id_width_lp),
      .els_p   (els_p)
   ) order_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (push),
      .data_i  (gnt_id),
      .ready_o (fifo_ready),
      .v_o     (fifo_v),
      .data_o  (head_id),
      .yumi_i  (pop),
      .count_o (fifo_count)
   );

   assign resp_live        = bus.resp_v_i & fifo_v & reset_i;
   assign pop              = resp_live & bus.ch_resp_ready_and_i[head_id];
   assign bus.resp_yumi_o  = pop;
   assign bus.ch_resp_o    = bus.resp_i;
   assign bus.ch_resp_v_o  = resp_live ? (num_ch_p'(1) << head_id) : '0;
   assign bus.inflight_o   = fifo_count;
   assign bus.orphan_o     = orphan_r;

   always_ff @(posedge clk_i) begin
      if (!reset_i)                     orphan_r <= 1'b0;
      else if (bus.resp_v_i && !fifo_v) orphan_r <= 1'b1;
   end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// tb/tb_bp_io_cmd_arbiter.sv - self-checking bench for bp_io_cmd_arbiter
module tb_bp_io_cmd_arbiter;
   localparam int num_ch_lp    = 4;
   localparam int msg_width_lp = 64;
   localparam int els_lp       = 8;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   bp_io_cmd_arbiter_if #(.num_ch_p(num_ch_lp), .msg_width_p(msg_width_lp), .els_p(els_lp)) bus ();

   bp_io_cmd_arbiter #(.num_ch_p(num_ch_lp), .msg_width_p(msg_width_lp), .els_p(els_lp)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;
   bit checking = 1'b0;

   // reference state: next round-robin start, stalled channel (-1 none), command order, orphan flag
   int m_ptr = 0;
   int m_hold = -1;
   int m_q[$];
   bit m_orphan = 1'b0;

   logic [num_ch_lp-1:0]    s_yumi, s_resp_v;
   logic                    s_cmd_v, s_resp_yumi, s_orphan;
   logic [3:0]              s_inflight;
   logic [msg_width_lp-1:0] s_cmd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] v, input logic [3:0] en, input logic rdy,
                         input logic rv, input logic [3:0] rr);
      bus.ch_cmd_v_i          = v;
      bus.ch_en_i             = en;
      bus.cmd_ready_and_i     = rdy;
      bus.resp_v_i            = rv;
      bus.ch_resp_ready_and_i = rr;
   endtask

   task automatic fixed_data();
      for (int i = 0; i < num_ch_lp; i++) bus.ch_cmd_i[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      bus.resp_i = 64'h5A5A_1234_5678_9ABC;
   endtask

   // one clock: compare against the model, advance the model, move to the next falling edge
   task automatic cycle();
      int g, h;
      bit was_empty, live, e_cmd_v, e_resp_yumi;
      logic [num_ch_lp-1:0] elig, e_yumi, e_resp_v;
      #1;
      s_yumi = bus.ch_cmd_yumi_o;   s_resp_v = bus.ch_resp_v_o;
      s_cmd_v = bus.cmd_v_o;        s_resp_yumi = bus.resp_yumi_o;
      s_orphan = bus.orphan_o;      s_inflight = bus.inflight_o;
      s_cmd = bus.cmd_o;

      elig = '0;
      g = -1;
      was_empty = (m_q.size() == 0);
      if (reset_i && m_q.size() < els_lp) elig = bus.ch_cmd_v_i & bus.ch_en_i;
      if (m_hold >= 0 && elig[m_hold]) g = m_hold;
      else for (int k = 0; k < num_ch_lp; k++)
         if (g < 0 && elig[(m_ptr + k) % num_ch_lp]) g = (m_ptr + k) % num_ch_lp;
      e_cmd_v = (g >= 0);
      e_yumi = (e_cmd_v && bus.cmd_ready_and_i) ? num_ch_lp'(1 << g) : '0;
      live = reset_i && bus.resp_v_i && !was_empty;
      h = was_empty ? 0 : m_q[0];
      e_resp_v = live ? num_ch_lp'(1 << h) : '0;
      e_resp_yumi = live && bus.ch_resp_ready_and_i[h];

      if (checking) begin
         chk("cmd_v", 64'(s_cmd_v), 64'(e_cmd_v));
         if (e_cmd_v) chk("cmd_data", s_cmd, bus.ch_cmd_i[g]);
         chk("ch_cmd_yumi", 64'(s_yumi), 64'(e_yumi));
         chk("ch_resp_v", 64'(s_resp_v), 64'(e_resp_v));
         chk("resp_yumi", 64'(s_resp_yumi), 64'(e_resp_yumi));
         chk("ch_resp_data", bus.ch_resp_o, bus.resp_i);
         chk("inflight", 64'(s_inflight), 64'(m_q.size()));
         chk("orphan", 64'(s_orphan), 64'(m_orphan));
      end

      if (!reset_i) begin
         m_q.delete();
         m_ptr = 0;
         m_hold = -1;
         m_orphan = 1'b0;
      end else begin
         if (e_resp_yumi) void'(m_q.pop_front());
         if (e_yumi != 0) begin
            m_q.push_back(g);
            m_ptr = (g + 1) % num_ch_lp;
         end
         m_hold = (e_cmd_v && !bus.cmd_ready_and_i) ? g : -1;
         if (bus.resp_v_i && was_empty) m_orphan = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      cycle();
      reset_i = 1'b1;
   endtask

   initial begin
      int n_yumi;
      reset_i = 1'b0;
      fixed_data();
      set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111);
      @(negedge clk);
      @(negedge clk);
      checking = 1'b1;

      // reset state with every input active
      cycle();
      chk("rst_cmd_v", 64'(s_cmd_v), 64'd0);
      chk("rst_yumi", 64'(s_yumi), 64'd0);
      chk("rst_inflight", 64'(s_inflight), 64'd0);
      reset_i = 1'b1;

      // channels 0 and 1 alternate, then four responses drain
      set_in(4'b0011, 4'b1111, 1'b1, 1'b0, 4'b1111);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk($sformatf("alt_grant%0d", k), 64'(s_yumi), 64'(k % 2 == 0 ? 4'b0001 : 4'b0010));
      end
      set_in(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk($sformatf("alt_resp%0d", k), 64'(s_resp_v), 64'(k % 2 == 0 ? 4'b0001 : 4'b0010));
      end
      set_in(4'b0000, 4'b1111, 1'b1, 1'b0, 4'b1111);
      cycle();
      chk("alt_inflight_zero", 64'(s_inflight), 64'd0);

      // fill the order FIFO with responses withheld
      do_reset();
      set_in(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111);
      n_yumi = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (s_yumi != 0) n_yumi++;
      end
      chk("full_yumi_count", 64'(n_yumi), 64'd8);
      chk("full_cmd_v", 64'(s_cmd_v), 64'd0);
      chk("full_inflight", 64'(s_inflight), 64'd8);
      set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111);
      cycle();
      chk("full_pop_cmd_v", 64'(s_cmd_v), 64'd0);
      chk("full_pop_resp", 64'(s_resp_v), 64'(4'b0001));
      set_in(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111);
      cycle();
      chk("refill_yumi", 64'(s_yumi), 64'(4'b0001));

      // stall on channel 1 while channel 0 also requests
      do_reset();
      set_in(4'b0010, 4'b1111, 1'b0, 1'b0, 4'b1111);
      cycle();
      set_in(4'b0011, 4'b1111, 1'b0, 1'b0, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk($sformatf("stall_cmd%0d", k), s_cmd, 64'hA5A5_0000_0000_0001);
      end
      set_in(4'b0011, 4'b1111, 1'b1, 1'b0, 4'b1111);
      cycle();
      chk("stall_release", 64'(s_yumi), 64'(4'b0010));
      set_in(4'b0110, 4'b1111, 1'b0, 1'b0, 4'b1111);
      cycle();
      set_in(4'b0110, 4'b1011, 1'b0, 1'b0, 4'b1111);
      cycle();
      chk("disable_regrant", s_cmd, 64'hA5A5_0000_0000_0001);

      // response ordering 2, 0, 2 with channel 0 back-pressuring
      do_reset();
      set_in(4'b0100, 4'b1111, 1'b1, 1'b0, 4'b1111); cycle();
      set_in(4'b0001, 4'b1111, 1'b1, 1'b0, 4'b1111); cycle();
      set_in(4'b0100, 4'b1111, 1'b1, 1'b0, 4'b1111); cycle();
      set_in(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111); cycle();
      chk("order0", 64'(s_resp_v), 64'(4'b0100));
      set_in(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1110);
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk($sformatf("order1_blocked_v%0d", k), 64'(s_resp_v), 64'(4'b0001));
         chk($sformatf("order1_blocked_yumi%0d", k), 64'(s_resp_yumi), 64'd0);
      end
      set_in(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111);
      cycle();
      chk("order1", 64'(s_resp_v), 64'(4'b0001));
      cycle();
      chk("order2", 64'(s_resp_v), 64'(4'b0100));
      set_in(4'b0000, 4'b1111, 1'b1, 1'b0, 4'b1111);
      cycle();
      chk("order_drained", 64'(s_inflight), 64'd0);

      // orphan response
      do_reset();
      set_in(4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111);
      cycle();
      chk("orphan_no_yumi", 64'(s_resp_yumi), 64'd0);
      set_in(4'b0000, 4'b1111, 1'b1, 1'b0, 4'b1111);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk($sformatf("orphan_sticky%0d", k), 64'(s_orphan), 64'd1);
      end
      do_reset();
      cycle();
      chk("orphan_cleared", 64'(s_orphan), 64'd0);

      // reset with three commands in flight
      do_reset();
      set_in(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111);
      for (int k = 0; k < 3; k++) cycle();
      reset_i = 1'b0;
      set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111);
      cycle();
      chk("midrst_cmd_v", 64'(s_cmd_v), 64'd0);
      chk("midrst_resp_v", 64'(s_resp_v), 64'd0);
      chk("midrst_inflight_before", 64'(s_inflight), 64'd3);
      reset_i = 1'b1;
      set_in(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111);
      cycle();
      chk("midrst_inflight", 64'(s_inflight), 64'd0);
      chk("midrst_resume", 64'(s_yumi), 64'(4'b0001));

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset_i = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < num_ch_lp; i++) bus.ch_cmd_i[i] = {$urandom, $urandom};
         bus.resp_i = {$urandom, $urandom};
         set_in(4'($urandom), 4'($urandom | $urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0), 4'($urandom | $urandom));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
